// File: rtl/sram_ctrl.sv
// sram_ctrl: bus-side responder for an external 1M x 16 async SRAM.
// All pin-facing outputs are registered; one word per request.
module sram_ctrl #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  parameter int TURN    = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [19:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_be,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  input  logic [15:0] SRAM_DQ_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_TURN,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } state_t;

  localparam int MAXC = (RD_WAIT > WR_WAIT)
                      ? ((RD_WAIT > TURN) ? RD_WAIT : TURN)
                      : ((WR_WAIT > TURN) ? WR_WAIT : TURN);
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  // Down-counter reload values: a phase of N cycles loads N-1.
  localparam logic [CW-1:0] RD_LD = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LD = CW'(WR_WAIT - 1);
  localparam logic [CW-1:0] TN_LD = (TURN > 0) ? CW'(TURN - 1) : '0;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [19:0]   addr_q, addr_d;
  logic [15:0]   dout_q, dout_d;
  logic          dqoe_q, dqoe_d;
  logic          ce_n_q, ce_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          ub_n_q, ub_n_d;
  logic          lb_n_q, lb_n_d;
  logic          rvld_q, rvld_d;
  logic [15:0]   rdata_q, rdata_d;

  assign req_ready   = (state_q == S_IDLE) && !Reset;
  assign rsp_valid   = rvld_q;
  assign rsp_rdata   = rdata_q;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_CE_N   = ce_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_UB_N   = ub_n_q;
  assign SRAM_LB_N   = lb_n_q;
  assign SRAM_DQ_out = dout_q;
  assign SRAM_DQ_oe  = dqoe_q;

  // Next-state and next-pin values; pins change only via the flops below.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    dqoe_d  = dqoe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    ub_n_d  = ub_n_q;
    lb_n_d  = lb_n_q;
    rvld_d  = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          ce_n_d = 1'b0;
          we_n_d = 1'b1;
          if (req_we) begin
            state_d = S_WR_SETUP;
            oe_n_d  = 1'b1;
            ub_n_d  = ~req_be[1];
            lb_n_d  = ~req_be[0];
            dqoe_d  = 1'b1;
            dout_d  = req_wdata;
          end else begin
            state_d = S_RD;
            cnt_d   = RD_LD;
            oe_n_d  = 1'b0;
            ub_n_d  = 1'b0;
            lb_n_d  = 1'b0;
            dqoe_d  = 1'b0;
          end
        end
      end
      S_RD: begin
        if (cnt_q == '0) begin
          rdata_d = SRAM_DQ_in;
          rvld_d  = 1'b1;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          ub_n_d  = 1'b1;
          lb_n_d  = 1'b1;
          if (TURN > 0) begin
            state_d = S_TURN;
            cnt_d   = TN_LD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_TURN: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = WR_LD;
        we_n_d  = 1'b0;
      end
      S_WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_WR_HOLD;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WR_HOLD: begin
        state_d = S_IDLE;
        ce_n_d  = 1'b1;
        dqoe_d  = 1'b0;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        rvld_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dqoe_d  = 1'b0;
      end
    endcase
  end

  // State and pin registers; reset drops every control inactive at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      dqoe_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      dqoe_q  <= dqoe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed bench for sram_ctrl with default timing
// parameters and a behavioural async SRAM model.
module tb_sram_ctrl;

  logic        Clk;
  logic        Reset;
  logic        req_valid;
  logic        req_we;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;
  logic [15:0] SRAM_DQ_out;
  logic        SRAM_DQ_oe;
  logic [15:0] SRAM_DQ_in;

  int checks;
  int errors;
  int viol;

  logic [15:0] mem [logic [19:0]];

  sram_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_be      (req_be),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .SRAM_ADDR   (SRAM_ADDR),
    .SRAM_CE_N   (SRAM_CE_N),
    .SRAM_OE_N   (SRAM_OE_N),
    .SRAM_WE_N   (SRAM_WE_N),
    .SRAM_UB_N   (SRAM_UB_N),
    .SRAM_LB_N   (SRAM_LB_N),
    .SRAM_DQ_out (SRAM_DQ_out),
    .SRAM_DQ_oe  (SRAM_DQ_oe),
    .SRAM_DQ_in  (SRAM_DQ_in)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] rd_mem(input logic [19:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  // SRAM model: byte writes while CE_N and WE_N are low.
  always @(posedge Clk) begin
    logic [15:0] w;
    if (!Reset && !SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_oe) begin
      w = rd_mem(SRAM_ADDR);
      if (!SRAM_UB_N) w[15:8] = SRAM_DQ_out[15:8];
      if (!SRAM_LB_N) w[7:0] = SRAM_DQ_out[7:0];
      mem[SRAM_ADDR] = w;
    end
  end

  // SRAM model: read data presented while CE_N and OE_N are low.
  always @(negedge Clk) begin
    if (!SRAM_CE_N && !SRAM_OE_N) SRAM_DQ_in = rd_mem(SRAM_ADDR);
    else SRAM_DQ_in = 16'h0000;
  end

  // Bus-contention monitor.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (!SRAM_OE_N && !SRAM_WE_N) viol++;
      if (!SRAM_OE_N && SRAM_DQ_oe) viol++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!req_ready && n < 20) begin
      step;
      n++;
    end
    chk("ready_wait", req_ready, 1);
  endtask

  task automatic issue(input logic we, input logic [19:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    wait_ready;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
  endtask

  task automatic do_write(input logic [19:0] a, input logic [15:0] d,
                          input logic [1:0] be);
    issue(1'b1, a, d, be);
    step;
    req_valid = 1'b0;
    chk("wr1_ce", SRAM_CE_N, 0);
    chk("wr1_we", SRAM_WE_N, 1);
    chk("wr1_oe", SRAM_DQ_oe, 1);
    chk("wr1_addr", SRAM_ADDR, a);
    chk("wr1_data", SRAM_DQ_out, d);
    chk("wr1_rdy", req_ready, 0);
    step;
    chk("wr2_we", SRAM_WE_N, 0);
    chk("wr2_ub", SRAM_UB_N, !be[1]);
    chk("wr2_lb", SRAM_LB_N, !be[0]);
    step;
    chk("wr3_we", SRAM_WE_N, 0);
    step;
    chk("wr4_we", SRAM_WE_N, 1);
    chk("wr4_ce", SRAM_CE_N, 0);
    chk("wr4_rv", rsp_valid, 0);
    step;
    chk("wr5_rv", rsp_valid, 1);
    chk("wr5_rdy", req_ready, 1);
    chk("wr5_ce", SRAM_CE_N, 1);
    chk("wr5_dqoe", SRAM_DQ_oe, 0);
  endtask

  task automatic do_read(input logic [19:0] a, input logic [15:0] exp);
    issue(1'b0, a, 16'h0000, 2'b00);
    step;
    req_valid = 1'b0;
    chk("rd1_ce", SRAM_CE_N, 0);
    chk("rd1_oe", SRAM_OE_N, 0);
    chk("rd1_we", SRAM_WE_N, 1);
    chk("rd1_bytes", {SRAM_UB_N, SRAM_LB_N}, 0);
    chk("rd1_dqoe", SRAM_DQ_oe, 0);
    chk("rd1_addr", SRAM_ADDR, a);
    step;
    chk("rd2_oe", SRAM_OE_N, 0);
    chk("rd2_rv", rsp_valid, 0);
    step;
    chk("rd3_rv", rsp_valid, 1);
    chk("rd3_data", rsp_rdata, exp);
    chk("rd3_oe", SRAM_OE_N, 1);
    chk("rd3_rdy", req_ready, 0);
    step;
    chk("rd4_rdy", req_ready, 1);
    chk("rd4_rv", rsp_valid, 0);
    chk("rd4_hold", rsp_rdata, exp);
  endtask

  initial begin
    int seen;
    checks    = 0;
    errors    = 0;
    viol      = 0;
    Reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    #2 Reset = 1'b1;
    #1;
    chk("rst_ctl", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
                    SRAM_UB_N, SRAM_LB_N}, 5'h1f);
    chk("rst_dqoe", SRAM_DQ_oe, 0);
    chk("rst_addr", SRAM_ADDR, 0);
    chk("rst_dout", SRAM_DQ_out, 0);
    chk("rst_rv", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_rdy", req_ready, 0);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    step;
    chk("post_rdy", req_ready, 1);
    chk("post_rv", rsp_valid, 0);

    do_write(20'h00123, 16'hBEEF, 2'b11);
    chk("mem_beef", rd_mem(20'h00123), 16'hBEEF);
    do_read(20'h00123, 16'hBEEF);

    do_write(20'h00123, 16'h1234, 2'b01);
    chk("mem_be01", rd_mem(20'h00123), 16'hBE34);
    do_read(20'h00123, 16'hBE34);

    do_write(20'h00123, 16'hFFFF, 2'b00);
    chk("mem_be00", rd_mem(20'h00123), 16'hBE34);
    do_read(20'h00123, 16'hBE34);

    // Back-to-back: write then read with req_valid held high.
    issue(1'b1, 20'h00200, 16'hA5A5, 2'b11);
    step;
    req_we   = 1'b0;
    req_addr = 20'h00200;
    for (int i = 0; i < 3; i++) begin
      chk("b2b_busy", req_ready, 0);
      step;
    end
    chk("b2b_hold", SRAM_WE_N, 1);
    step;
    chk("b2b_rv", rsp_valid, 1);
    chk("b2b_rdy", req_ready, 1);
    step;
    req_valid = 1'b0;
    chk("b2b_oe", SRAM_OE_N, 0);
    chk("b2b_addr", SRAM_ADDR, 20'h00200);
    step;
    step;
    chk("b2b_rdrv", rsp_valid, 1);
    chk("b2b_data", rsp_rdata, 16'hA5A5);

    // Reset during the write pulse aborts the write.
    issue(1'b1, 20'h00400, 16'h5555, 2'b11);
    step;
    req_valid = 1'b0;
    step;
    chk("ab_we_lo", SRAM_WE_N, 0);
    #2 Reset = 1'b1;
    #1;
    chk("ab_we", SRAM_WE_N, 1);
    chk("ab_ce", SRAM_CE_N, 1);
    chk("ab_dqoe", SRAM_DQ_oe, 0);
    chk("ab_rdy", req_ready, 0);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step;
      if (rsp_valid) seen++;
    end
    chk("ab_norv", seen, 0);
    chk("ab_mem", rd_mem(20'h00400), 16'h0000);
    do_read(20'h00123, 16'hBE34);

    chk("contention", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- SRAM-side responder for the CPU memory bus; performs the physical access cycles against the external 1M x 16 asynchronous SRAM.
- Accepts single-word read/write requests through a valid/ready handshake and drives registered, glitch-free CE_N/OE_N/WE_N/UB_N/LB_N/address/data-enable.
- Returns read data with a one-cycle rsp_valid pulse.
- No address decode: switch/hex I/O mapping is handled upstream; the DQ tristate buffer is instantiated at top level.

Parameters:
- RD_WAIT, 2, cycles OE_N/CE_N held low before read data is sampled (>=1).
- WR_WAIT, 2, cycles WE_N held low per write (>=1).
- TURN, 1, idle cycles after a read before the next request is accepted (>=0).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  20  word address.
- req_wdata  in  16  write data.
- req_be  in  2  byte enables for writes; [1] = upper byte, [0] = lower byte.
- req_ready  out  1  block can accept a request this cycle.
- rsp_valid  out  1  one-cycle completion pulse (reads and writes).
- rsp_rdata  out  16  last read data; holds until the next read completes.
- SRAM_ADDR  out  20  registered address to the SRAM.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM controls.
- SRAM_DQ_out  out  16  write data to the tristate buffer.
- SRAM_DQ_oe  out  1  tristate enable; 1 = drive DQ.
- SRAM_DQ_in  in  16  data from the SRAM DQ pins.

Behaviour:
- Reset (async, takes effect immediately):
  - State IDLE.
  - All *_N outputs 1; SRAM_DQ_oe 0; SRAM_ADDR 0; SRAM_DQ_out 0; rsp_valid 0; rsp_rdata 0.
  - req_ready 0 while Reset is high.
  - A reset mid-transaction aborts it: controls go inactive at once and no rsp_valid is issued.
- All SRAM-side outputs come from flops. No combinational path from req_* to the pins.
- req_ready = (state == IDLE) and not Reset.
- A request is accepted on any edge where req_valid & req_ready. addr, wdata, be and we are latched at that edge.
- States: IDLE, RD, TURN, WR_SETUP, WR_PULSE, WR_HOLD.
- Read:
  - Cycle after acceptance enters RD: CE_N=0, OE_N=0, WE_N=1, UB_N=LB_N=0 (req_be ignored), DQ_oe=0.
  - Stays in RD for RD_WAIT cycles, counted by a down-counter.
  - On the edge ending the last RD cycle: rsp_rdata <= SRAM_DQ_in; rsp_valid <= 1; CE_N, OE_N <= 1.
  - Next state is TURN if TURN>0, else IDLE. TURN lasts TURN cycles with all controls inactive, then IDLE.
  - Latency: acceptance edge k -> rsp_valid high in cycle k+RD_WAIT+1.
- Write:
  - WR_SETUP, 1 cycle: CE_N=0, WE_N=1, OE_N=1, UB_N=~be[1], LB_N=~be[0], DQ_oe=1, DQ_out=wdata.
  - WR_PULSE, WR_WAIT cycles: as WR_SETUP but WE_N=0.
  - WR_HOLD, 1 cycle: WE_N=1; CE_N, DQ_oe, address and data unchanged.
  - Then IDLE with CE_N=1, DQ_oe=0, and rsp_valid=1 in that first IDLE cycle.
  - Latency: acceptance at k -> rsp_valid in cycle k+WR_WAIT+3, coincident with req_ready=1.
  - A new request may be accepted in that same cycle.
- req_be = 00 on a write runs the full cycle with UB_N=LB_N=1 (no byte written) and still completes with rsp_valid.
- SRAM_ADDR changes only on an acceptance edge. Address and data are stable for the entire CE_N-low window.
- WE_N is never low while OE_N is low. DQ_oe is never 1 while OE_N is low.
- rsp_valid is a single-cycle pulse. The block does not wait for the requester to acknowledge it.

Test Plan:
- Reset, default params: pulse Reset mid-cycle -> all *_N=1 and DQ_oe=0 asynchronously; after release req_ready=1 and rsp_valid=0.
- Write addr 20'h00123, wdata 16'hBEEF, be=11 at edge 0 -> WR_SETUP cycle 1, WE_N low cycles 2-3, hold cycle 4, rsp_valid and req_ready in cycle 5; the SRAM model holds BEEF.
- Read addr 20'h00123 with the model returning BEEF -> OE_N low cycles 1-2, rsp_valid with rsp_rdata=16'hBEEF in cycle 3, req_ready=1 in cycle 4.
- Write wdata 16'h1234 with be=01 over a stored 16'hBEEF -> LB_N=0, UB_N=1; a read-back returns 16'hBE34. With be=00 -> data unchanged and rsp_valid still pulses.
- Back-to-back: req_valid held high with write then read -> second request accepted in the write's rsp_valid cycle; no WE_N/OE_N overlap; DQ_oe=0 before OE_N falls (checked by assertion).
- Assert Reset during WR_PULSE -> WE_N rises immediately, no rsp_valid; the next read after release completes normally.
